// File: rtl/sram_addr_gen_if.sv
// ---------------------------------------------------------------------------
// sram_addr_gen_if
//
// Bundles the signals between the command decoder / SNES bus and the SRAM
// address generator.
//
//   sreg_en_n  : serial load enable, active low          (master -> slave)
//   si         : serial data bit                         (master -> slave)
//   si_strobe  : sample si on this cycle                 (master -> slave)
//   counter_n  : increment request, falling-edge active  (master -> slave)
//   snes_mode  : 1 = drive SNES address onto SRAM        (master -> slave)
//   snes_addr  : SNES-side address                       (master -> slave)
//   sram_addr  : address presented to the SRAM pins      (slave -> master)
//   addr_reg   : committed internal address (debug)      (slave -> master)
//   bit_cnt    : bits shifted in the current load        (slave -> master)
//   busy       : serial load in progress                 (slave -> master)
//   load_done  : one-cycle pulse on commit               (slave -> master)
//   wrap       : one-cycle pulse when an increment wraps (slave -> master)
// ---------------------------------------------------------------------------
interface sram_addr_gen_if #(
    parameter int ADDR_WIDTH = 21
);
    localparam int CNT_WIDTH = $clog2(ADDR_WIDTH + 1);

    logic                  sreg_en_n;
    logic                  si;
    logic                  si_strobe;
    logic                  counter_n;
    logic                  snes_mode;
    logic [ADDR_WIDTH-1:0] snes_addr;
    logic [ADDR_WIDTH-1:0] sram_addr;
    logic [ADDR_WIDTH-1:0] addr_reg;
    logic [CNT_WIDTH-1:0]  bit_cnt;
    logic                  busy;
    logic                  load_done;
    logic                  wrap;

    modport master (
        output sreg_en_n, si, si_strobe, counter_n, snes_mode, snes_addr,
        input  sram_addr, addr_reg, bit_cnt, busy, load_done, wrap
    );

    modport slave (
        input  sreg_en_n, si, si_strobe, counter_n, snes_mode, snes_addr,
        output sram_addr, addr_reg, bit_cnt, busy, load_done, wrap
    );
endinterface

// File: rtl/sram_addr_gen.sv
// ---------------------------------------------------------------------------
// sram_addr_gen
//
// SRAM address generator for the AVR-to-SRAM path. The AVR shifts an address
// in serially; a bit counter tracks progress and the address is committed
// either when all ADDR_WIDTH bits have arrived or when the AVR releases the
// load enable early (partial load, unshifted bits stay 0). While idle, every
// falling edge of counter_n advances the committed address by STEP, wrapping
// past ADDR_MAX. The SRAM address pins are muxed between the internal address
// and the SNES bus.
//
// Ports:
//   avr_clk   : system clock, all logic on the rising edge
//   avr_reset : asynchronous active-high reset
//   bus       : sram_addr_gen_if slave modport (see interface header)
//
// Parameters:
//   ADDR_WIDTH : address width
//   ADDR_MAX   : highest legal address; incrementing past it wraps
//   STEP       : increment per counter pulse, 1 <= STEP <= ADDR_MAX
//   MSB_FIRST  : 1 = bits enter at the LSB and move toward the MSB
//                0 = bits enter at the MSB and move toward the LSB
// ---------------------------------------------------------------------------
module sram_addr_gen #(
    parameter int                    ADDR_WIDTH = 21,
    parameter logic [ADDR_WIDTH-1:0] ADDR_MAX   = {ADDR_WIDTH{1'b1}},
    parameter int                    STEP       = 1,
    parameter bit                    MSB_FIRST  = 1'b1
) (
    input  logic           avr_clk,
    input  logic           avr_reset,
    sram_addr_gen_if.slave bus
);

    localparam int CNT_WIDTH = $clog2(ADDR_WIDTH + 1);

    // Increment arithmetic is one bit wider than the address so neither the
    // sum nor the wrap threshold can overflow silently.
    localparam logic [ADDR_WIDTH:0]  MAX_X    = {1'b0, ADDR_MAX};
    localparam logic [ADDR_WIDTH:0]  STEP_X   = (ADDR_WIDTH + 1)'(STEP);
    localparam logic [ADDR_WIDTH:0]  LIMIT_X  = MAX_X + 1'b1;
    localparam logic [ADDR_WIDTH:0]  THRESH_X = MAX_X - STEP_X;
    localparam logic [CNT_WIDTH-1:0] FULL_CNT = CNT_WIDTH'(ADDR_WIDTH);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        COMMIT = 2'd2
    } state_t;

    state_t                  state_reg;
    state_t                  state_next;
    logic [ADDR_WIDTH-1:0]   shift_reg;
    logic [ADDR_WIDTH-1:0]   addr_reg_q;
    logic [CNT_WIDTH-1:0]    bit_cnt_reg;
    logic                    counter_n_reg;
    logic                    wrap_reg;

    logic                    take_bit;
    logic [CNT_WIDTH-1:0]    bit_cnt_next;
    logic [ADDR_WIDTH-1:0]   shift_next;
    logic                    start_load;
    logic                    inc_fire;
    logic [ADDR_WIDTH:0]     inc_sum;
    logic                    inc_wraps;
    logic [ADDR_WIDTH-1:0]   inc_addr;
    logic                    busy_c;
    logic                    load_done_c;

    // ------------------------------------------------------------------
    // Serial datapath helpers
    // ------------------------------------------------------------------
    // A strobe only counts in SHIFT and only until the buffer is full;
    // anything beyond that is ignored.
    assign take_bit     = (state_reg == SHIFT) && bus.si_strobe &&
                          (bit_cnt_reg < FULL_CNT);
    assign bit_cnt_next = bit_cnt_reg + {{(CNT_WIDTH-1){1'b0}}, take_bit};

    generate
        if (MSB_FIRST) begin : g_msb_first
            assign shift_next = {shift_reg[ADDR_WIDTH-2:0], bus.si};
        end else begin : g_lsb_first
            assign shift_next = {bus.si, shift_reg[ADDR_WIDTH-1:1]};
        end
    endgenerate

    // Any transition into SHIFT starts a fresh load.
    assign start_load = (state_next == SHIFT) && (state_reg != SHIFT);

    // ------------------------------------------------------------------
    // Increment helpers
    // ------------------------------------------------------------------
    // Falling edge of counter_n, honoured only in IDLE. Edges seen during a
    // load or commit are simply lost, which also makes commit win over a
    // coincident increment.
    assign inc_fire  = (state_reg == IDLE) && counter_n_reg && !bus.counter_n;
    assign inc_sum   = {1'b0, addr_reg_q} + STEP_X;
    assign inc_wraps = ({1'b0, addr_reg_q} > THRESH_X);
    assign inc_addr  = ADDR_WIDTH'(inc_wraps ? (inc_sum - LIMIT_X) : inc_sum);

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge avr_clk or posedge avr_reset) begin
        if (avr_reset) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_next = state_reg;
        unique case (state_reg)
            IDLE: begin
                if (!bus.sreg_en_n) begin
                    state_next = SHIFT;
                end
            end
            SHIFT: begin
                // Uses the count including this cycle's strobe so that a
                // strobe coinciding with release is taken before committing.
                if (bit_cnt_next == FULL_CNT) begin
                    state_next = COMMIT;
                end else if (bus.sreg_en_n) begin
                    state_next = (bit_cnt_next != '0) ? COMMIT : IDLE;
                end
            end
            COMMIT: begin
                state_next = bus.sreg_en_n ? IDLE : SHIFT;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: output logic
    // ------------------------------------------------------------------
    always_comb begin
        busy_c      = 1'b0;
        load_done_c = 1'b0;
        unique case (state_reg)
            SHIFT:   busy_c      = 1'b1;
            COMMIT:  load_done_c = 1'b1;
            default: ;
        endcase
    end

    // ------------------------------------------------------------------
    // Shift buffer and bit counter
    // ------------------------------------------------------------------
    always_ff @(posedge avr_clk or posedge avr_reset) begin
        if (avr_reset) begin
            shift_reg   <= '0;
            bit_cnt_reg <= '0;
        end else if (start_load) begin
            shift_reg   <= '0;
            bit_cnt_reg <= '0;
        end else if (take_bit) begin
            shift_reg   <= shift_next;
            bit_cnt_reg <= bit_cnt_next;
        end
    end

    // ------------------------------------------------------------------
    // Committed address, counter edge detect and wrap pulse
    // ------------------------------------------------------------------
    always_ff @(posedge avr_clk or posedge avr_reset) begin
        if (avr_reset) begin
            addr_reg_q    <= '0;
            counter_n_reg <= 1'b1;   // idle-high, so releasing reset is not an edge
            wrap_reg      <= 1'b0;
        end else begin
            counter_n_reg <= bus.counter_n;
            wrap_reg      <= 1'b0;
            if (state_reg == COMMIT) begin
                addr_reg_q <= shift_reg;
            end else if (inc_fire) begin
                addr_reg_q <= inc_addr;
                wrap_reg   <= inc_wraps;
            end
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign bus.sram_addr = bus.snes_mode ? bus.snes_addr : addr_reg_q;
    assign bus.addr_reg  = addr_reg_q;
    assign bus.bit_cnt   = bit_cnt_reg;
    assign bus.busy      = busy_c;
    assign bus.load_done = load_done_c;
    assign bus.wrap      = wrap_reg;

endmodule

// File: tb/tb_sram_addr_gen.sv
// ---------------------------------------------------------------------------
// tb_sram_addr_gen
//
// Two instances share one stimulus stream: dut0 uses the default parameters
// (21-bit, STEP 1, full range), dut1 uses ADDR_MAX=0x0FFFFF and STEP=4.
// Committed loads on dut0 are checked through a queue of expected addresses;
// increment behaviour is checked from a table of vectors against a small
// reference model; the multi-cycle corner cases are written out by hand.
// ---------------------------------------------------------------------------
module tb_sram_addr_gen;

    localparam int AW = 21;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          sreg_en_n = 1'b1;
    logic          si = 1'b0;
    logic          si_strobe = 1'b0;
    logic          counter_n = 1'b1;
    logic          snes_mode = 1'b0;
    logic [AW-1:0] snes_addr = '0;

    always #5 clk = ~clk;

    sram_addr_gen_if #(.ADDR_WIDTH(AW)) if0 ();
    sram_addr_gen_if #(.ADDR_WIDTH(AW)) if1 ();

    assign if0.sreg_en_n = sreg_en_n;
    assign if0.si        = si;
    assign if0.si_strobe = si_strobe;
    assign if0.counter_n = counter_n;
    assign if0.snes_mode = snes_mode;
    assign if0.snes_addr = snes_addr;
    assign if1.sreg_en_n = sreg_en_n;
    assign if1.si        = si;
    assign if1.si_strobe = si_strobe;
    assign if1.counter_n = counter_n;
    assign if1.snes_mode = snes_mode;
    assign if1.snes_addr = snes_addr;

    sram_addr_gen #(
        .ADDR_WIDTH(AW)
    ) dut0 (
        .avr_clk   (clk),
        .avr_reset (rst),
        .bus       (if0)
    );

    sram_addr_gen #(
        .ADDR_WIDTH(AW),
        .ADDR_MAX  (21'h0FFFFF),
        .STEP      (4)
    ) dut1 (
        .avr_clk   (clk),
        .avr_reset (rst),
        .bus       (if1)
    );

    int            n_cmp = 0;
    int            n_bad = 0;
    logic [AW-1:0] exp_q[$];
    int            loads_seen = 0;
    int            wrap0_cnt = 0;
    int            wrap1_cnt = 0;
    bit            ld_seen = 1'b0;

    typedef struct {
        logic [AW-1:0] start;
        int            pulses;
        int            hold;
        logic [AW-1:0] exp_addr;
        int            exp_wraps;
    } inc_vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [AW-1:0] model_inc(input logic [AW-1:0] a,
                                                 input longint step,
                                                 input longint amax);
        longint v;
        v = longint'(a);
        if (v > amax - step) v = v + step - (amax + 1);
        else                 v = v + step;
        return AW'(v);
    endfunction

    // Scoreboard: one commit on dut0 pops one expected address, compared the
    // cycle after load_done (when addr_reg has taken the buffer).
    always @(negedge clk) begin
        if (rst) begin
            ld_seen = 1'b0;
        end else begin
            if (if0.wrap) wrap0_cnt++;
            if (if1.wrap) wrap1_cnt++;
            if (ld_seen) begin
                loads_seen++;
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL sb_unexpected_load: got addr 0x%06h, expected no commit", if0.addr_reg);
                end else begin
                    logic [AW-1:0] e;
                    e = exp_q.pop_front();
                    check("sb_load", 32'(if0.addr_reg), 32'(e));
                    $display("load commit: addr_reg=0x%06h expected=0x%06h", if0.addr_reg, e);
                end
            end
            ld_seen = if0.load_done;
        end
    end

    // Serial load of the low nbits of val, MSB first; releasing with nbits=0
    // must not commit, so nothing is expected in that case.
    task automatic load(input logic [AW-1:0] val, input int nbits);
        logic [AW-1:0] e;
        e = '0;
        sreg_en_n = 1'b0;
        tick();
        for (int i = nbits - 1; i >= 0; i--) begin
            si        = val[i];
            si_strobe = 1'b1;
            e[i]      = val[i];
            tick();
        end
        si_strobe = 1'b0;
        si        = 1'b0;
        sreg_en_n = 1'b1;
        if (nbits > 0) exp_q.push_back(e);
        repeat (3) tick();
    endtask

    task automatic pulse_counter(input int hold);
        counter_n = 1'b0;
        repeat (hold) tick();
        counter_n = 1'b1;
        repeat (2) tick();
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time budget");
        $fatal(1, "timeout");
    end

    initial begin
        inc_vec_t      vecs[4];
        logic [AW-1:0] model;
        int            w_before;
        int            l_before;

        vecs[0] = '{21'h000010, 2, 1, 21'h000012, 0};
        vecs[1] = '{21'h000010, 1, 5, 21'h000011, 0};
        vecs[2] = '{21'h1FFFFF, 1, 1, 21'h000000, 1};
        vecs[3] = '{21'h004CCF, 3, 2, 21'h004CD2, 0};

        // ---------------- reset state ----------------
        #2;
        check("rst_busy",      32'(if0.busy),      32'd0);
        check("rst_bit_cnt",   32'(if0.bit_cnt),   32'd0);
        check("rst_addr_reg",  32'(if0.addr_reg),  32'd0);
        check("rst_sram_addr", 32'(if0.sram_addr), 32'd0);
        check("rst_load_done", 32'(if0.load_done), 32'd0);
        check("rst_wrap",      32'(if0.wrap),      32'd0);
        tick();
        rst = 1'b0;
        repeat (3) tick();
        check("post_rst_no_inc", 32'(if0.addr_reg), 32'd0);

        // ---------------- full load, latency ----------------
        sreg_en_n = 1'b0;
        tick();
        check("full_busy", 32'(if0.busy), 32'd1);
        for (int i = AW - 1; i >= 0; i--) begin
            logic [AW-1:0] v;
            v         = 21'h004CCF;
            si        = v[i];
            si_strobe = 1'b1;
            tick();
        end
        si_strobe = 1'b0;
        sreg_en_n = 1'b1;
        exp_q.push_back(21'h004CCF);
        check("full_bit_cnt",   32'(if0.bit_cnt),   32'd21);
        check("full_load_done", 32'(if0.load_done), 32'd1);
        tick();
        check("full_addr_reg",  32'(if0.addr_reg),  32'h004CCF);
        check("full_sram_addr", 32'(if0.sram_addr), 32'h004CCF);
        check("full_done_pulse", 32'(if0.load_done), 32'd0);
        repeat (2) tick();

        // ---------------- partial loads ----------------
        load(21'h1FFFFF, AW);
        load(21'h004CCF, 16);
        check("partial_addr", 32'(if0.addr_reg), 32'h004CCF);
        l_before = loads_seen;
        load(21'h000000, 0);
        check("empty_no_commit", 32'(loads_seen - l_before), 32'd0);
        check("empty_addr_kept", 32'(if0.addr_reg), 32'h004CCF);

        // ---------------- mode mux ----------------
        snes_addr = 21'h1ABCDE;
        snes_mode = 1'b1;
        #1;
        check("snes_sram_addr", 32'(if0.sram_addr), 32'h1ABCDE);
        check("snes_addr_reg",  32'(if0.addr_reg),  32'h004CCF);
        snes_mode = 1'b0;
        #1;
        check("int_sram_addr",  32'(if0.sram_addr), 32'h004CCF);
        tick();

        // ---------------- increment vectors ----------------
        for (int v = 0; v < 4; v++) begin
            load(vecs[v].start, AW);
            model    = vecs[v].start;
            w_before = wrap0_cnt;
            for (int p = 0; p < vecs[v].pulses; p++) begin
                pulse_counter(vecs[v].hold);
                model = model_inc(model, 1, 64'h1FFFFF);
                check("inc_step", 32'(if0.addr_reg), 32'(model));
            end
            check("inc_final", 32'(if0.addr_reg), 32'(vecs[v].exp_addr));
            check("inc_wraps", 32'(wrap0_cnt - w_before), 32'(vecs[v].exp_wraps));
            $display("inc vector %0d: start=0x%06h addr=0x%06h", v, vecs[v].start, if0.addr_reg);
        end

        // ---------------- step 4 / reduced limit wrap (dut1) ----------------
        load(21'h0FFFFE, AW);
        check("d1_loaded", 32'(if1.addr_reg), 32'h0FFFFE);
        w_before = wrap1_cnt;
        pulse_counter(1);
        check("d1_wrap_addr", 32'(if1.addr_reg), 32'(model_inc(21'h0FFFFE, 4, 64'h0FFFFF)));
        check("d1_wrap_pulses", 32'(wrap1_cnt - w_before), 32'd1);

        // ---------------- counter edge during COMMIT ----------------
        sreg_en_n = 1'b0;
        tick();
        for (int i = AW - 1; i >= 0; i--) begin
            logic [AW-1:0] v;
            v         = 21'h000123;
            si        = v[i];
            si_strobe = 1'b1;
            tick();
        end
        si_strobe = 1'b0;
        sreg_en_n = 1'b1;
        exp_q.push_back(21'h000123);
        check("coll_in_commit", 32'(if0.load_done), 32'd1);
        counter_n = 1'b0;
        repeat (3) tick();
        counter_n = 1'b1;
        repeat (2) tick();
        check("coll_no_inc", 32'(if0.addr_reg), 32'h000123);

        // ---------------- reset mid-load ----------------
        sreg_en_n = 1'b0;
        tick();
        for (int i = 0; i < 7; i++) begin
            si        = i[0];
            si_strobe = 1'b1;
            tick();
        end
        check("mid_bit_cnt", 32'(if0.bit_cnt), 32'd7);
        rst = 1'b1;
        #1;
        check("mid_rst_busy",    32'(if0.busy),     32'd0);
        check("mid_rst_bit_cnt", 32'(if0.bit_cnt),  32'd0);
        check("mid_rst_addr",    32'(if0.addr_reg), 32'd0);
        si_strobe = 1'b0;
        sreg_en_n = 1'b1;
        tick();
        rst = 1'b0;
        tick();
        load(21'h000001, AW);
        check("after_rst_load", 32'(if0.addr_reg), 32'h000001);

        check("sb_drained", 32'(exp_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/sram_addr_gen.md
Name: sram_addr_gen

Overview:
- Parametrised successor to the fixed 21-bit serial address register and separate address counter in the AVR-to-SRAM path.
- One block loads an SRAM address serially from the AVR, counts loaded bits and commits on completion or early release.
- Auto-increments by a programmable step with wrap at a programmable limit.
- Muxes in the SNES address bus when SNES mode is active. Sits between cmd decode and the SRAM address pins.

Parameters:
- ADDR_WIDTH, 21, width of the address register and output bus.
- ADDR_MAX, 2**ADDR_WIDTH-1, highest legal address; increment past it wraps to 0.
- STEP, 1, increment amount per counter pulse; must be >=1 and <=ADDR_MAX.
- MSB_FIRST, 1, 1 = serial bits enter at LSB and shift toward MSB (first bit ends up MSB); 0 = bits enter at MSB and shift toward LSB.

Ports:
- avr_clk  input  1  system clock, all logic on rising edge.
- avr_reset  input  1  asynchronous active-high reset.
- sreg_en_n  input  1  serial load enable, active low.
- si  input  1  serial data bit.
- si_strobe  input  1  one-cycle-qualified shift strobe; sample si when high.
- counter_n  input  1  increment request, active low; acts on its falling edge.
- snes_mode  input  1  1 = output the SNES address, 0 = output the internal address.
- snes_addr  input  ADDR_WIDTH  SNES-side address.
- sram_addr  output  ADDR_WIDTH  address to SRAM.
- addr_reg  output  ADDR_WIDTH  committed internal address (debug).
- bit_cnt  output  clog2(ADDR_WIDTH+1)  bits shifted in the current load.
- busy  output  1  high while in SHIFT.
- load_done  output  1  one-cycle pulse on commit.
- wrap  output  1  one-cycle pulse when an increment wraps.

Behaviour:
- Reset (async, avr_reset=1): state=IDLE, shift buffer=0, addr_reg=0, bit_cnt=0, busy=0, load_done=0, wrap=0. The counter_n edge register is set to 1, so there is no spurious edge on release. sram_addr follows the mux, giving 0 when snes_mode=0.
- FSM states: IDLE, SHIFT, COMMIT.
- IDLE -> SHIFT when sreg_en_n=0. On entry the shift buffer is cleared and bit_cnt=0.
- SHIFT: each cycle with si_strobe=1, shift si into the buffer per MSB_FIRST and increment bit_cnt.
  - If bit_cnt reaches ADDR_WIDTH, go to COMMIT on the next edge; further strobes are ignored.
  - If sreg_en_n returns to 1 with 0 < bit_cnt < ADDR_WIDTH, go to COMMIT (partial load). Unshifted bits remain 0, so a partial load with MSB_FIRST=1 is right-aligned.
  - If sreg_en_n returns to 1 with bit_cnt=0, go to IDLE without committing; addr_reg is unchanged.
  - If si_strobe and the sreg_en_n release occur in the same cycle, the strobed bit is taken first, then COMMIT.
- COMMIT (one cycle): addr_reg <= buffer, load_done=1 for exactly that cycle.
  - Next state is IDLE if sreg_en_n=1, else SHIFT with a fresh clear.
- Latency: addr_reg updates on the edge leaving COMMIT. sram_addr reflects it the following cycle in internal mode, which is 2 cycles after the final strobe for a full load.
- Increment:
  - Falling edge = registered counter_n was 1 and current counter_n is 0. It is acted on only in IDLE.
  - Edges seen in SHIFT or COMMIT are dropped, not queued.
  - New addr = addr_reg+STEP. If addr_reg > ADDR_MAX-STEP, new addr = addr_reg+STEP-(ADDR_MAX+1) and wrap=1 for one cycle.
  - Arithmetic is done at ADDR_WIDTH+1 bits so there is no silent overflow.
- Simultaneous commit and increment edge: commit wins and the increment is dropped.
- sram_addr = snes_mode ? snes_addr : addr_reg. This is a combinational mux, with no effect on FSM or counter state; loads and increments proceed while in SNES mode.
- Reset mid-SHIFT discards the partial buffer; addr_reg returns to 0.
- busy=1 exactly while state=SHIFT.

Test Plan:
- Full load, 21 strobes with MSB_FIRST=1 shifting 0x04CCF zero-extended (MSB first) -> bit_cnt reaches 21, one load_done pulse, addr_reg=sram_addr=0x004CCF two cycles after the last strobe.
- Partial load, 16 strobes of 0x4CCF then sreg_en_n=1 -> load_done pulse, addr_reg=0x004CCF. Release with 0 strobes -> no load_done, addr_reg unchanged.
- Increment, addr_reg=0x000010, two counter_n low pulses separated by high -> 0x000011 then 0x000012, wrap never asserted. Holding counter_n low for 5 cycles -> only one increment.
- Wrap, ADDR_WIDTH=21, STEP=1, addr_reg=0x1FFFFF, one counter_n falling edge -> addr_reg=0x000000, wrap high for one cycle. With ADDR_MAX=0x0FFFFF and STEP=4 from 0x0FFFFE -> 0x000002, wrap=1.
- Mode mux and collision:
  - snes_mode=1, snes_addr=0x1ABCDE -> sram_addr=0x1ABCDE while addr_reg holds 0x004CCF; snes_mode=0 restores 0x004CCF.
  - counter_n falling edge in the COMMIT cycle -> no increment.
- Reset mid-load: avr_reset pulsed after 7 strobes -> busy=0, bit_cnt=0, addr_reg=0 immediately (asynchronous). A following full load of 0x000001 succeeds.
